// File: rtl/core_ctrl_if.sv
// Controller-side bundle for core_ctrl: run control, ofifo status, accumulation
// table lookup, the registered instruction word and a debug view of the FSM state.
interface core_ctrl_if;
  logic        start;
  logic        ofifo_valid;
  logic [15:0] aq_idx;
  logic [10:0] aq_addr;
  logic [33:0] inst;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  // ofifo_valid is the only flow control: ofifo_rd (with its pmem write) is issued
  // only from a cycle whose decision saw ofifo_valid=1; aq_addr must answer aq_idx
  // combinationally in the same cycle.
  modport master (
    input  start, ofifo_valid, aq_addr,
    output aq_idx, inst, busy, done, dbg_state
  );
  modport slave (
    output start, ofifo_valid, aq_addr,
    input  aq_idx, inst, busy, done, dbg_state
  );
endinterface

// File: rtl/core_ctrl.sv
// Sequencer for the PE core: weight load, execute/drain per kernel position, then
// accumulation. Define CORE_CTRL_RELU_EN to emit relu after each accumulated pixel.
module core_ctrl #(
  parameter int          ROW       = 8,
  parameter int          COL       = 8,
  parameter int          LEN_NIJ   = 100,
  parameter int          LEN_KIJ   = 9,
  parameter int          LEN_ONIJ  = 64,
  parameter int          NUM_WSET  = 2,
  parameter int          OFIFO_LAT = 16,
  parameter logic [10:0] WBASE     = 11'h400
) (
  input logic         clk,
  input logic         reset,
  core_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, WLOAD = 3'd1, WFLUSH = 3'd2, SETTLE = 3'd3,
    EXEC = 3'd4, DRAIN = 3'd5, ACC = 3'd6, DONE = 3'd7
  } state_t;

  localparam logic [33:0] IDLE_INST   = 34'h1_800C_0000;
  localparam logic [15:0] COL_LAST    = 16'(COL - 1);
  localparam logic [15:0] FLUSH_LAST  = 16'(ROW);
  localparam logic [15:0] SETTLE_LAST = 16'd16;
  localparam logic [15:0] NIJ_LAST    = 16'(LEN_NIJ - 1);
  localparam logic [15:0] NIJ_CNT     = 16'(LEN_NIJ);
  localparam logic [15:0] LAT         = 16'(OFIFO_LAT);
  localparam logic [15:0] KIJ_CNT     = 16'(LEN_KIJ);
  localparam logic [15:0] KIJ_LAST    = 16'(LEN_KIJ - 1);
  localparam logic [15:0] ACC_LAST    = 16'(LEN_KIJ + 2);
  localparam logic [15:0] ONIJ_LAST   = 16'(LEN_ONIJ - 1);
  localparam logic [2:0]  WSET_LAST   = 3'(NUM_WSET - 1);

  state_t      state_q;
  logic [15:0] t_q, kij_q, onij_q, wr_cnt_q, aq_idx_q;
  logic [2:0]  set_q;
  logic [10:0] wptr_q;
  logic [33:0] inst_q, inst_d;
  logic        busy_q, done_q;
  logic        wr_en;
  logic        drained;
  logic [10:0] wl_addr;

  assign drained = (wr_cnt_q == NIJ_CNT);
  assign wl_addr = WBASE + 11'(32'(set_q) * COL) + t_q[10:0];

  // Decode of the current state/counter into the word registered at the next edge.
  always_comb begin
    inst_d = IDLE_INST;
    wr_en  = 1'b0;
    unique case (state_q)
      WLOAD: begin
        inst_d[19]   = 1'b0;
        inst_d[17:7] = wl_addr;
        if (t_q != 16'd0) begin
          inst_d[3] = 1'b1;
          inst_d[2] = 1'b1;
          inst_d[0] = 1'b1;
        end
      end
      WFLUSH: begin
        if (t_q < FLUSH_LAST) begin
          inst_d[3] = 1'b1;
          inst_d[0] = 1'b1;
          inst_d[2] = (t_q == 16'd0);
        end
      end
      SETTLE: inst_d[3] = (t_q < 16'd10);
      EXEC: begin
        inst_d[19]   = 1'b0;
        inst_d[17:7] = t_q[10:0] + 11'd1;
        inst_d[2]    = 1'b1;
        if (t_q != 16'd0) begin
          inst_d[3] = 1'b1;
          inst_d[1] = 1'b1;
        end
        wr_en = bus.ofifo_valid && (t_q >= LAT);
      end
      DRAIN: begin
        if (!drained) begin
          inst_d[3] = 1'b1;
          inst_d[1] = 1'b1;
          wr_en     = bus.ofifo_valid;
        end
      end
      ACC: begin
        if (t_q < KIJ_CNT) begin
          inst_d[32]    = 1'b0;
          inst_d[30:20] = bus.aq_addr;
        end
        inst_d[33] = (t_q != 16'd0) && (t_q <= KIJ_CNT);
`ifdef CORE_CTRL_RELU_EN
        inst_d[5] = (t_q == ACC_LAST);
`else
        inst_d[5] = 1'b0;
`endif
      end
      default: ;
    endcase
    if (wr_en) begin
      inst_d[6]     = 1'b1;
      inst_d[32]    = 1'b0;
      inst_d[31]    = 1'b0;
      inst_d[30:20] = wptr_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      inst_q   <= IDLE_INST;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      t_q      <= '0;
      set_q    <= '0;
      kij_q    <= '0;
      onij_q   <= '0;
      wr_cnt_q <= '0;
      wptr_q   <= '0;
      aq_idx_q <= '0;
    end else begin
      inst_q <= inst_d;
      done_q <= 1'b0;
      if (wr_en) begin
        wptr_q   <= wptr_q + 11'd1;
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q  <= WLOAD;
            busy_q   <= 1'b1;
            t_q      <= '0;
            set_q    <= '0;
            kij_q    <= '0;
            onij_q   <= '0;
            wr_cnt_q <= '0;
            wptr_q   <= '0;
            aq_idx_q <= '0;
          end
        end
        WLOAD: begin
          if (t_q == COL_LAST) begin
            state_q <= WFLUSH;
            t_q     <= '0;
          end else t_q <= t_q + 16'd1;
        end
        WFLUSH: begin
          if (t_q == FLUSH_LAST) begin
            t_q <= '0;
            if (set_q == WSET_LAST) begin
              set_q   <= '0;
              state_q <= SETTLE;
            end else begin
              set_q   <= set_q + 3'd1;
              state_q <= WLOAD;
            end
          end else t_q <= t_q + 16'd1;
        end
        SETTLE: begin
          if (t_q == SETTLE_LAST) begin
            state_q <= EXEC;
            t_q     <= '0;
          end else t_q <= t_q + 16'd1;
        end
        EXEC: begin
          if (t_q == NIJ_LAST) begin
            state_q <= DRAIN;
            t_q     <= '0;
          end else t_q <= t_q + 16'd1;
        end
        DRAIN: begin
          // The cycle that sees the last write landed is the single idle cycle.
          if (drained) begin
            wr_cnt_q <= '0;
            if (kij_q == KIJ_LAST) begin
              kij_q    <= '0;
              aq_idx_q <= '0;
              state_q  <= ACC;
            end else begin
              kij_q   <= kij_q + 16'd1;
              state_q <= WLOAD;
            end
          end
        end
        ACC: begin
          // aq_idx runs one read ahead so aq_addr is ready when the read issues.
          if (t_q < KIJ_CNT) aq_idx_q <= aq_idx_q + 16'd1;
          if (t_q == ACC_LAST) begin
            t_q <= '0;
            if (onij_q == ONIJ_LAST) begin
              onij_q  <= '0;
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else onij_q <= onij_q + 16'd1;
          end else t_q <= t_q + 16'd1;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.inst      = inst_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.aq_idx    = aq_idx_q;
  assign bus.dbg_state = state_q;
endmodule

// File: doc/core_ctrl.md
CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 SHALL have parameter ROW, 8, PE rows.
REQ-002 SHALL have parameter COL, 8, PE columns, which is also the weight words per set.
REQ-003 SHALL have parameter LEN_NIJ, 100, input pixels per kij.
REQ-004 SHALL have parameter LEN_KIJ, 9, kernel positions.
REQ-005 SHALL have parameter LEN_ONIJ, 64, output pixels.
REQ-006 SHALL have parameter NUM_WSET, 2, weight sets loaded per kij (legal range 1..4).
REQ-007 SHALL have parameter OFIFO_LAT, 16, EXEC cycles before ofifo reads are permitted.
REQ-008 SHALL have parameter WBASE, 11'h400, xmem base address of the weight words.
REQ-009 SHALL have port clk, input, 1, the single clock.
REQ-010 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-011 SHALL have ports start (input, 1, one-cycle pulse that begins a run) and ofifo_valid (input, 1, ofifo holds data).
REQ-012 SHALL have ports aq_idx (output, 16, accumulation-table index) and aq_addr (input, 11, pmem address for aq_idx, combinational and valid in the same cycle).
REQ-013 SHALL have ports inst (output, 34, registered instruction word) and busy, done (outputs, 1 each).
REQ-014 SHALL drive the inst bit layout as follows: [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6] ofifo_rd, [5] relu, [4] ififo_rd (tied 0), [3] l0_rd, [2] l0_wr, [1] execute, [0] load.

Function
REQ-015 SHALL use FSM states IDLE -> WLOAD -> WFLUSH -> SETTLE -> EXEC -> DRAIN, repeating per kij, then ACC -> DONE -> IDLE.
REQ-016 SHALL leave IDLE on start=1 and SHALL ignore start while busy=1.
REQ-017 WLOAD SHALL last COL cycles per set: CEN_xmem=0, WEN_xmem=1, A_xmem=WBASE+set*COL+t; l0_wr=l0_rd=load=1 for t>0.
REQ-018 WFLUSH SHALL last 9 cycles per set: l0_rd=1 and load=1 on cycles 0..7, l0_wr=1 on cycle 0 only, then load=0 on cycle 8; after the set it SHALL return to WLOAD until NUM_WSET sets are done.
REQ-019 SHALL hold SETTLE for 17 cycles: l0_rd=1 on the first 10 cycles, all controls idle thereafter.
REQ-020 EXEC SHALL last LEN_NIJ cycles: CEN_xmem=0, l0_wr=1, A_xmem=t+1; l0_rd=execute=1 for t>0; ofifo_rd=ofifo_valid for t>=OFIFO_LAT.
REQ-021 In EXEC and DRAIN, SHALL drive ofifo_rd=ofifo_valid, CEN_pmem=WEN_pmem=0 on the same cycle, and A_pmem=wptr; wptr SHALL increment after each such write.
REQ-022 DRAIN SHALL hold l0_rd=execute=1 until LEN_NIJ writes have completed for this kij, then SHALL emit one idle cycle.
REQ-023 SHALL start wptr at 0 on start and SHALL NOT reset it between kij; it SHALL wrap modulo 2^11.
REQ-024 In ACC, for each onij o, SHALL run LEN_KIJ+3 cycles.
REQ-025 ACC cycles j<LEN_KIJ SHALL drive CEN_pmem=0, WEN_pmem=1, A_pmem=aq_addr with aq_idx=o*LEN_KIJ+j.
REQ-026 ACC cycles j>0 and j<=LEN_KIJ SHALL drive acc=1; cycle LEN_KIJ+1 SHALL drive acc=0; cycle LEN_KIJ+2 SHALL drive relu per REQ-031.
REQ-027 SHALL pulse done=1 for one cycle in DONE; busy SHALL be 1 in every state except IDLE and DONE.
REQ-028 Idle inst value (all non-driving states) SHALL be: CEN and WEN bits = 1, all other bits = 0.

Reset
REQ-029 On reset=0, asynchronously and at any time including mid-run, SHALL set the state to IDLE, inst to the idle value, busy=done=0, and wptr, aq_idx and all counters to 0.
REQ-030 SHALL resume only on a new start pulse after reset deasserts.

Configuration
REQ-031 With CORE_CTRL_RELU_EN defined, SHALL drive relu=1 on ACC cycle LEN_KIJ+2; without it, relu SHALL be tied 0 and that cycle SHALL remain idle.

Verification
REQ-032 Defaults, ofifo_valid=1, start pulse -> done exactly once, wptr=900 at done, 900 pmem writes with addresses 0..899 in order.
REQ-033 Kij 0 WLOAD, set 1 -> A_xmem sequence 0x408..0x40F, load=1 from the second cycle.
REQ-034 ofifo_valid=0 for 50 DRAIN cycles -> no pmem writes, FSM holds in DRAIN, then completes when ofifo_valid returns to 1.
REQ-035 aq_addr=aq_idx[10:0] -> onij 0 reads addresses 0..8, acc=1 on 9 cycles, relu=1 only when CORE_CTRL_RELU_EN is defined.
REQ-036 reset=0 asserted mid-EXEC -> inst equals the idle value within the same cycle, busy=0; a new start pulse reruns from kij 0 with wptr=0.
REQ-037 start pulsed while busy=1 -> no effect; the total run length is unchanged.
